// File: rtl/vga_pkg.sv
// Shared VGA pixel types, colour widths and pattern mode codes used by the
// pattern generator pipeline and its sub-modules.
package vga_pkg;

   localparam int HC_W   = 10;
   localparam int VC_W   = 10;
   localparam int HX_W   = HC_W + 1;
   localparam int PIX_CW = 8;   // widest colour a frame carries; narrower CW uses the low bits
   localparam int PAT_W  = 4;
   localparam int MODE_W = 3;

   typedef enum logic [MODE_W-1:0] {
      MODE_BYPASS    = 3'd0,
      MODE_GRAY      = 3'd1,
      MODE_PRIMARY   = 3'd2,
      MODE_RAINBOW   = 3'd3,
      MODE_TRIBAND   = 3'd4,
      MODE_CHECKER   = 3'd5,
      MODE_BLACK     = 3'd6,
      MODE_BLACK_ALT = 3'd7
   } mode_e;

   typedef struct packed {
      logic [HC_W-1:0]   hc;
      logic [VC_W-1:0]   vc;
      logic              start;
      logic [PIX_CW-1:0] r;
      logic [PIX_CW-1:0] g;
      logic [PIX_CW-1:0] b;
   } vga_frame_t;

   typedef struct packed {
      logic [PAT_W-1:0] r;
      logic [PAT_W-1:0] g;
      logic [PAT_W-1:0] b;
   } pat_rgb_t;

   typedef struct packed {
      logic [HC_W-1:0]   hx;
      logic [HC_W-1:0]   hc;
      logic [VC_W-1:0]   vc;
      logic              start;
      mode_e             mode;
      logic [PIX_CW-1:0] r;
      logic [PIX_CW-1:0] g;
      logic [PIX_CW-1:0] b;
   } stage1_t;

   localparam logic [PAT_W-1:0] PAT_FULL = 4'hF;
   localparam logic [PAT_W-1:0] PAT_ZERO = 4'h0;

   function automatic pat_rgb_t pat_mono(input logic [PAT_W-1:0] v);
      return {v, v, v};
   endfunction

endpackage

// File: rtl/video_pattern_gen.sv
// Combinational colour pattern generator: maps shifted column hx, line vc and
// mode onto 4-bit r/g/b. Bypass is flagged so the top passes source colour.
module video_pattern_gen
   import vga_pkg::*;
#(
   parameter int V_DISPLAY = 480,
   parameter int CHK_LOG2  = 5
) (
   input  logic [HC_W-1:0] hx,
   input  logic [VC_W-1:0] vc,
   input  mode_e           mode,
   output pat_rgb_t        pat,
   output logic            bypass
);

   localparam logic [VC_W-1:0] BAND_1 = VC_W'(V_DISPLAY / 3);
   localparam logic [VC_W-1:0] BAND_2 = VC_W'(2 * (V_DISPLAY / 3));

   pat_rgb_t         gray;
   pat_rgb_t         primary;
   pat_rgb_t         rainbow;
   pat_rgb_t         chk_pat;
   logic [PAT_W-1:0] ramp_up;
   logic [PAT_W-1:0] ramp_dn;
   logic             unused_hx;

   assign unused_hx = ^hx[2:0];

   always_comb begin
      gray    = pat_mono(hx[8:5]);
      primary = {{PAT_W{hx[8]}}, {PAT_W{hx[7]}}, {PAT_W{hx[6]}}};
      ramp_up = hx[6:3];
      ramp_dn = ~hx[6:3];
      // Spectrum red -> yellow -> green -> cyan -> blue -> magenta, then white.
      case (hx[9:7])
         3'd0:    rainbow = {PAT_FULL, ramp_up, PAT_ZERO};
         3'd1:    rainbow = {ramp_dn, PAT_FULL, PAT_ZERO};
         3'd2:    rainbow = {PAT_ZERO, PAT_FULL, ramp_up};
         3'd3:    rainbow = {PAT_ZERO, ramp_dn, PAT_FULL};
         3'd4:    rainbow = {ramp_up, PAT_ZERO, PAT_FULL};
         default: rainbow = pat_mono(PAT_FULL);
      endcase
      chk_pat = pat_mono((hx[CHK_LOG2] ^ vc[CHK_LOG2]) ? PAT_FULL : PAT_ZERO);
   end

   always_comb begin
      pat    = pat_mono(PAT_ZERO);
      bypass = 1'b0;
      case (mode)
         MODE_BYPASS:  bypass = 1'b1;
         MODE_GRAY:    pat = gray;
         MODE_PRIMARY: pat = primary;
         MODE_RAINBOW: pat = rainbow;
         MODE_TRIBAND: begin
            if (vc < BAND_1) begin
               pat = gray;
            end else if (vc < BAND_2) begin
               pat = primary;
            end else begin
               pat = rainbow;
            end
         end
         MODE_CHECKER: pat = chk_pat;
         default:      pat = pat_mono(PAT_ZERO);
      endcase
   end

endmodule

// File: rtl/video_pattern_core.sv
// Two-stage test-pattern pipeline: per-frame mode and scroll offset are latched
// on accepted start pixels, colour is generated from the shifted column.
module video_pattern_core
   import vga_pkg::*;
#(
   parameter int CW          = 4,
   parameter int H_DISPLAY   = 640,
   parameter int V_DISPLAY   = 480,
   parameter int SCROLL_STEP = 4,
   parameter int CHK_LOG2    = 5,
   parameter int RESET_MODE  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic [MODE_W-1:0] mode,
   input  logic              scroll_en,
   input  logic              source_vld,
   input  vga_frame_t        source_frame,
   output logic              sink_vld,
   output vga_frame_t        sink_frame
);

   localparam logic [HX_W-1:0]   H_WRAP       = HX_W'(H_DISPLAY);
   localparam logic [HX_W-1:0]   OFF_STEP     = HX_W'(SCROLL_STEP);
   localparam mode_e             RESET_MODE_E = mode_e'(MODE_W'(RESET_MODE));
   localparam logic [PIX_CW-1:0] CMASK        = {PIX_CW{1'b1}} >> (PIX_CW - CW);

   // MSB-first replication of a 4-bit pattern level into the low CW bits.
   function automatic logic [PIX_CW-1:0] widen(input logic [PAT_W-1:0] v);
      logic [PIX_CW-1:0] w;
      int                k;
      w = '0;
      for (int i = 0; i < CW; i++) begin
         k    = (PAT_W - 1) - ((CW - 1 - i) % PAT_W);
         w[i] = v[k[1:0]];
      end
      return w;
   endfunction

   mode_e           mode_q, mode_d;
   logic [HC_W-1:0] off_cnt_q, off_cnt_d;
   logic [HC_W-1:0] frame_off_q, frame_off_d;
   logic            s1_vld_q, s1_vld_d;
   stage1_t         s1_q, s1_d;
   logic            sink_vld_q, sink_vld_d;
   vga_frame_t      sink_frame_q, sink_frame_d;

   logic            accept;
   logic            start_acc;
   mode_e           eff_mode;
   logic [HC_W-1:0] eff_off;
   logic [HX_W-1:0] hx_sum;
   logic [HC_W-1:0] hx;
   logic [HX_W-1:0] off_sum;
   logic [HC_W-1:0] off_next;
   pat_rgb_t        gen_pat;
   logic            gen_bypass;

   video_pattern_gen #(
      .V_DISPLAY (V_DISPLAY),
      .CHK_LOG2  (CHK_LOG2)
   ) u_gen (
      .hx     (s1_q.hx),
      .vc     (s1_q.vc),
      .mode   (s1_q.mode),
      .pat    (gen_pat),
      .bypass (gen_bypass)
   );

   always_comb begin
      accept    = source_vld && !stall;
      start_acc = accept && source_frame.start;
      eff_mode  = start_acc ? mode_e'(mode) : mode_q;
      eff_off   = start_acc ? off_cnt_q : frame_off_q;
      hx_sum    = {1'b0, source_frame.hc} + {1'b0, eff_off};
      hx        = (hx_sum >= H_WRAP) ? HC_W'(hx_sum - H_WRAP) : HC_W'(hx_sum);
      off_sum   = {1'b0, off_cnt_q} + OFF_STEP;
      off_next  = (off_sum >= H_WRAP) ? HC_W'(off_sum - H_WRAP) : HC_W'(off_sum);

      mode_d      = mode_q;
      off_cnt_d   = off_cnt_q;
      frame_off_d = frame_off_q;
      if (start_acc) begin
         mode_d      = mode_e'(mode);
         frame_off_d = off_cnt_q;
         if (scroll_en) begin
            off_cnt_d = off_next;
         end
      end

      s1_vld_d = s1_vld_q;
      s1_d     = s1_q;
      if (!stall) begin
         s1_vld_d = source_vld;
      end
      if (accept) begin
         s1_d.hx    = hx;
         s1_d.hc    = source_frame.hc;
         s1_d.vc    = source_frame.vc;
         s1_d.start = source_frame.start;
         s1_d.mode  = eff_mode;
         s1_d.r     = source_frame.r;
         s1_d.g     = source_frame.g;
         s1_d.b     = source_frame.b;
      end

      // Bubbles advance the valid bit only; the last pixel's data is retained.
      sink_vld_d   = sink_vld_q;
      sink_frame_d = sink_frame_q;
      if (!stall) begin
         sink_vld_d = s1_vld_q;
         if (s1_vld_q) begin
            sink_frame_d.hc    = s1_q.hc;
            sink_frame_d.vc    = s1_q.vc;
            sink_frame_d.start = s1_q.start;
            sink_frame_d.r     = gen_bypass ? (s1_q.r & CMASK) : widen(gen_pat.r);
            sink_frame_d.g     = gen_bypass ? (s1_q.g & CMASK) : widen(gen_pat.g);
            sink_frame_d.b     = gen_bypass ? (s1_q.b & CMASK) : widen(gen_pat.b);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q       <= RESET_MODE_E;
         off_cnt_q    <= '0;
         frame_off_q  <= '0;
         s1_vld_q     <= 1'b0;
         s1_q         <= '0;
         sink_vld_q   <= 1'b0;
         sink_frame_q <= '0;
      end else begin
         mode_q       <= mode_d;
         off_cnt_q    <= off_cnt_d;
         frame_off_q  <= frame_off_d;
         s1_vld_q     <= s1_vld_d;
         s1_q         <= s1_d;
         sink_vld_q   <= sink_vld_d;
         sink_frame_q <= sink_frame_d;
      end
   end

   assign sink_vld   = sink_vld_q;
   assign sink_frame = sink_frame_q;

endmodule

// File: tb/tb_video_pattern_core.sv
// Directed bench for video_pattern_core: each pattern mode, frame-boundary mode
// sampling, stall hold, scroll offset wrap and asynchronous reset.
`timescale 1ns/1ps
module tb_video_pattern_core;
   import vga_pkg::*;

   localparam int CW    = 8;
   localparam int H     = 640;
   localparam int V     = 480;
   localparam int STEP  = 4;
   localparam int CHK   = 5;
   localparam int RMODE = 3;

   typedef struct {
      logic [2:0]  m;
      int          hc;
      int          vc;
      logic        st;
      logic [23:0] rgb;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic [2:0]  mode;
   logic        scroll_en;
   logic        source_vld;
   vga_frame_t  source_frame;
   logic        sink_vld;
   vga_frame_t  sink_frame;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   video_pattern_core #(
      .CW          (CW),
      .H_DISPLAY   (H),
      .V_DISPLAY   (V),
      .SCROLL_STEP (STEP),
      .CHK_LOG2    (CHK),
      .RESET_MODE  (RMODE)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .mode         (mode),
      .scroll_en    (scroll_en),
      .source_vld   (source_vld),
      .source_frame (source_frame),
      .sink_vld     (sink_vld),
      .sink_frame   (sink_frame)
   );

   function automatic vga_frame_t mk(input int hc, input int vc, input logic st, input logic [23:0] rgb);
      vga_frame_t f;
      f.hc    = HC_W'(hc);
      f.vc    = VC_W'(vc);
      f.start = st;
      f.r     = rgb[23:16];
      f.g     = rgb[15:8];
      f.b     = rgb[7:0];
      return f;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int hc, input int vc, input logic st, input logic [23:0] rgb);
      source_vld   = 1'b1;
      source_frame = mk(hc, vc, st, rgb);
   endtask

   task automatic send(input int hc, input int vc, input logic st, input logic [23:0] rgb);
      drive(hc, vc, st, rgb);
      tick();
   endtask

   task automatic bubble();
      source_vld         = 1'b0;
      source_frame.start = 1'b0;
   endtask

   task automatic do_reset();
      bubble();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      vga_frame_t e;
      rst = 1'b1; stall = 1'b0; mode = 3'd0; scroll_en = 1'b0;
      source_vld = 1'b0; source_frame = '0;
      repeat (3) tick();
      n_cmp++; if (sink_vld !== 1'b0) begin n_bad++; $display("FAIL reset_vld got %b want 0", sink_vld); end
      n_cmp++; if (sink_frame !== '0) begin n_bad++; $display("FAIL reset_frame got %h want 0", sink_frame); end
      n_cmp++; if (dut.mode_q !== 3'(RMODE)) begin n_bad++; $display("FAIL reset_mode got %0d want %0d", dut.mode_q, RMODE); end
      n_cmp++; if (dut.off_cnt_q !== '0) begin n_bad++; $display("FAIL reset_off got %0d want 0", dut.off_cnt_q); end
      rst = 1'b0;
      tick();
      mode = 3'd0;
      send(0, 0, 1'b1, 24'h112233);
      n_cmp++; if (sink_vld !== 1'b0) begin n_bad++; $display("FAIL latency1_vld got %b want 0", sink_vld); end
      bubble();
      tick();
      e = mk(0, 0, 1'b1, 24'h112233);
      n_cmp++; if (sink_vld !== 1'b1 || sink_frame !== e) begin n_bad++; $display("FAIL latency2 got %b/%h want 1/%h", sink_vld, sink_frame, e); end
      tick();
      n_cmp++; if (sink_vld !== 1'b0) begin n_bad++; $display("FAIL bubble_vld got %b want 0", sink_vld); end
   endtask

   task automatic test_patterns();
      vec_t       tbl[$];
      vga_frame_t e;
      tbl.push_back('{3'd1,   0,   0, 1'b1, 24'h000000});
      tbl.push_back('{3'd1, 100,  10, 1'b0, 24'h333333});
      tbl.push_back('{3'd1, 300,   0, 1'b0, 24'h999999});
      tbl.push_back('{3'd2, 448,   0, 1'b1, 24'hFFFFFF});
      tbl.push_back('{3'd2, 320,   0, 1'b0, 24'hFF00FF});
      tbl.push_back('{3'd2,  64,   0, 1'b0, 24'h0000FF});
      tbl.push_back('{3'd2, 128,   0, 1'b0, 24'h00FF00});
      tbl.push_back('{3'd3,  40,   0, 1'b1, 24'hFF5500});
      tbl.push_back('{3'd3, 136,   0, 1'b0, 24'hEEFF00});
      tbl.push_back('{3'd3, 300,   0, 1'b0, 24'h00FF55});
      tbl.push_back('{3'd3, 420,   0, 1'b0, 24'h00BBFF});
      tbl.push_back('{3'd3, 600,   0, 1'b0, 24'hBB00FF});
      tbl.push_back('{3'd4, 136,   0, 1'b1, 24'h444444});
      tbl.push_back('{3'd4, 136, 159, 1'b0, 24'h444444});
      tbl.push_back('{3'd4, 136, 160, 1'b0, 24'h00FF00});
      tbl.push_back('{3'd4, 136, 319, 1'b0, 24'h00FF00});
      tbl.push_back('{3'd4, 136, 320, 1'b0, 24'hEEFF00});
      tbl.push_back('{3'd4, 136, 479, 1'b0, 24'hEEFF00});
      tbl.push_back('{3'd5,   0,   0, 1'b1, 24'h000000});
      tbl.push_back('{3'd5,  32,   0, 1'b0, 24'hFFFFFF});
      tbl.push_back('{3'd5,   0,  32, 1'b0, 24'hFFFFFF});
      tbl.push_back('{3'd5,  32,  32, 1'b0, 24'h000000});
      tbl.push_back('{3'd5,  96,   0, 1'b0, 24'hFFFFFF});
      tbl.push_back('{3'd6, 100,   5, 1'b1, 24'h000000});
      tbl.push_back('{3'd7, 200,   5, 1'b1, 24'h000000});
      tbl.push_back('{3'd0,  10,  20, 1'b1, 24'h5AA53C});
      tbl.push_back('{3'd0, 639, 479, 1'b0, 24'h5AA53C});
      for (int i = 0; i <= tbl.size(); i++) begin
         if (i < tbl.size()) begin
            mode = tbl[i].m;
            drive(tbl[i].hc, tbl[i].vc, tbl[i].st, 24'h5AA53C);
         end else begin
            bubble();
         end
         tick();
         if (i > 0) begin
            e = mk(tbl[i-1].hc, tbl[i-1].vc, tbl[i-1].st, tbl[i-1].rgb);
            n_cmp++;
            if (sink_vld !== 1'b1 || sink_frame !== e) begin
               n_bad++;
               $display("FAIL pattern_%0d got %b/%h want 1/%h", i - 1, sink_vld, sink_frame, e);
            end
         end
      end
      bubble();
      tick();
   endtask

   task automatic test_mode_change();
      vga_frame_t e;
      mode = 3'd0;
      send(0, 0, 1'b1, 24'h102030);
      bubble(); tick();
      e = mk(0, 0, 1'b1, 24'h102030);
      n_cmp++; if (sink_frame !== e) begin n_bad++; $display("FAIL mc_start got %h want %h", sink_frame, e); end
      mode = 3'd5;
      send(32, 0, 1'b0, 24'h405060);
      bubble(); tick();
      e = mk(32, 0, 1'b0, 24'h405060);
      n_cmp++; if (sink_frame !== e) begin n_bad++; $display("FAIL mc_midframe got %h want %h", sink_frame, e); end
      source_vld = 1'b0; source_frame.start = 1'b1;
      tick();
      send(64, 0, 1'b0, 24'h708090);
      bubble(); tick();
      e = mk(64, 0, 1'b0, 24'h708090);
      n_cmp++; if (sink_frame !== e) begin n_bad++; $display("FAIL mc_invalid_start got %h want %h", sink_frame, e); end
      send(0, 0, 1'b1, 24'h708090);
      bubble(); tick();
      e = mk(0, 0, 1'b1, 24'h000000);
      n_cmp++; if (sink_frame !== e) begin n_bad++; $display("FAIL mc_next_start got %h want %h", sink_frame, e); end
      mode = 3'd0;
      send(32, 0, 1'b0, 24'h708090);
      bubble(); tick();
      e = mk(32, 0, 1'b0, 24'hFFFFFF);
      n_cmp++; if (sink_frame !== e) begin n_bad++; $display("FAIL mc_checker_white got %h want %h", sink_frame, e); end
   endtask

   task automatic test_stall();
      vga_frame_t ea, eb, ec;
      ea = mk(1, 1, 1'b1, 24'h010203);
      eb = mk(2, 1, 1'b0, 24'h040506);
      ec = mk(3, 1, 1'b0, 24'h070809);
      mode = 3'd0;
      send(1, 1, 1'b1, 24'h010203);
      send(2, 1, 1'b0, 24'h040506);
      drive(3, 1, 1'b0, 24'h070809);
      stall = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         n_cmp++;
         if (sink_vld !== 1'b1 || sink_frame !== ea) begin
            n_bad++;
            $display("FAIL stall_hold_%0d got %b/%h want 1/%h", i, sink_vld, sink_frame, ea);
         end
      end
      n_cmp++; if (dut.s1_q.hc !== HC_W'(2)) begin n_bad++; $display("FAIL stall_s1 got %0d want 2", dut.s1_q.hc); end
      stall = 1'b0;
      tick();
      n_cmp++; if (sink_vld !== 1'b1 || sink_frame !== eb) begin n_bad++; $display("FAIL stall_b got %b/%h want 1/%h", sink_vld, sink_frame, eb); end
      bubble();
      tick();
      n_cmp++; if (sink_vld !== 1'b1 || sink_frame !== ec) begin n_bad++; $display("FAIL stall_c got %b/%h want 1/%h", sink_vld, sink_frame, ec); end
      tick();
      n_cmp++; if (sink_vld !== 1'b0) begin n_bad++; $display("FAIL stall_drain got %b want 0", sink_vld); end
   endtask

   task automatic test_scroll();
      int         exp_off;
      int         exp_frame;
      vga_frame_t e;
      do_reset();
      mode = 3'd1;
      scroll_en = 1'b1;
      for (int f = 0; f < 200; f++) begin
         send(0, 0, 1'b1, 24'h000000);
         exp_off   = ((f + 1) * STEP) % H;
         exp_frame = (f * STEP) % H;
         n_cmp++;
         if (dut.off_cnt_q !== HC_W'(exp_off) || dut.frame_off_q !== HC_W'(exp_frame)) begin
            n_bad++;
            $display("FAIL scroll_frame_%0d got %0d/%0d want %0d/%0d", f, dut.off_cnt_q, dut.frame_off_q, exp_off, exp_frame);
         end
      end
      do_reset();
      send(0, 0, 1'b1, 24'h000000);
      send(0, 0, 1'b1, 24'h000000);
      n_cmp++; if (dut.s1_q.hx !== HC_W'(4)) begin n_bad++; $display("FAIL scroll_start_hx got %0d want 4", dut.s1_q.hx); end
      scroll_en = 1'b0;
      send(638, 3, 1'b0, 24'h000000);
      n_cmp++; if (dut.s1_q.hx !== HC_W'(2)) begin n_bad++; $display("FAIL scroll_wrap_hx got %0d want 2", dut.s1_q.hx); end
      bubble(); tick();
      e = mk(638, 3, 1'b0, 24'h000000);
      n_cmp++; if (sink_frame !== e) begin n_bad++; $display("FAIL scroll_wrap_out got %h want %h", sink_frame, e); end
      send(0, 0, 1'b1, 24'h000000);
      n_cmp++;
      if (dut.off_cnt_q !== HC_W'(8) || dut.frame_off_q !== HC_W'(8)) begin
         n_bad++;
         $display("FAIL scroll_freeze got %0d/%0d want 8/8", dut.off_cnt_q, dut.frame_off_q);
      end
      bubble(); tick();
   endtask

   task automatic test_reset_midframe();
      vga_frame_t e;
      mode = 3'd1;
      scroll_en = 1'b1;
      send(0, 0, 1'b1, 24'h000000);
      send(5, 0, 1'b0, 24'h000000);
      drive(6, 0, 1'b0, 24'h000000);
      stall = 1'b1;
      tick();
      #2;
      rst = 1'b1;
      #1;
      n_cmp++; if (sink_vld !== 1'b0) begin n_bad++; $display("FAIL arst_vld got %b want 0", sink_vld); end
      n_cmp++; if (sink_frame !== '0) begin n_bad++; $display("FAIL arst_frame got %h want 0", sink_frame); end
      n_cmp++; if (dut.s1_vld_q !== 1'b0) begin n_bad++; $display("FAIL arst_s1_vld got %b want 0", dut.s1_vld_q); end
      n_cmp++; if (dut.mode_q !== 3'(RMODE)) begin n_bad++; $display("FAIL arst_mode got %0d want %0d", dut.mode_q, RMODE); end
      n_cmp++;
      if (dut.off_cnt_q !== '0 || dut.frame_off_q !== '0) begin
         n_bad++;
         $display("FAIL arst_off got %0d/%0d want 0/0", dut.off_cnt_q, dut.frame_off_q);
      end
      tick();
      rst = 1'b0;
      stall = 1'b0;
      scroll_en = 1'b0;
      bubble();
      tick();
      mode = 3'd0;
      send(7, 7, 1'b1, 24'h0A0B0C);
      n_cmp++; if (sink_vld !== 1'b0) begin n_bad++; $display("FAIL arst_lat1 got %b want 0", sink_vld); end
      bubble(); tick();
      e = mk(7, 7, 1'b1, 24'h0A0B0C);
      n_cmp++; if (sink_vld !== 1'b1 || sink_frame !== e) begin n_bad++; $display("FAIL arst_lat2 got %b/%h want 1/%h", sink_vld, sink_frame, e); end
   endtask

   initial begin
      rst = 1'b1;
      stall = 1'b0;
      mode = 3'd0;
      scroll_en = 1'b0;
      source_vld = 1'b0;
      source_frame = '0;
      test_reset();
      test_patterns();
      test_mode_change();
      test_stall();
      test_scroll();
      test_reset_midframe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/video_pattern_core.md
VIDEO_PATTERN_CORE -- requirements
Module: video_pattern_core

Interface
REQ-001 SHALL have parameter CW, default 4: output colour component width (CW >= 4), applied to r/g/b.
REQ-002 SHALL have parameter H_DISPLAY, default 640: active pixels per line; scroll wrap modulus.
REQ-003 SHALL have parameter V_DISPLAY, default 480: active lines; tri-band split at V_DISPLAY/3 and 2*(V_DISPLAY/3).
REQ-004 SHALL have parameter SCROLL_STEP, default 4: pixels added to the scroll offset per frame.
REQ-005 SHALL have parameter CHK_LOG2, default 5: checker square size 2^CHK_LOG2 pixels.
REQ-006 SHALL have parameter RESET_MODE, default 0: mode register value after reset.
REQ-007 clk  input  1  the single clock; all state on its rising edge.
REQ-008 rst  input  1  reset, asynchronous and active-high.
REQ-009 stall  input  1  downstream back-pressure; when 1 all pipeline and frame state holds.
REQ-010 mode  input  3  requested pattern; sampled only at accepted frame-start pixels.
REQ-011 scroll_en  input  1  enables per-frame horizontal offset advance.
REQ-012 source_vld  input  1  upstream pixel valid.
REQ-013 source_frame  input  vga_frame_t  upstream pixel (hc, vc, start, r, g, b).
REQ-014 sink_vld  output  1  downstream pixel valid, registered.
REQ-015 sink_frame  output  vga_frame_t  downstream pixel, registered.

Function
REQ-016 Accept = source_vld && !stall; only accepted pixels update mode/offset state.
REQ-017 Mode codes: 0 bypass (r/g/b pass through), 1 16-level gray bars from hx[8:5], 2 eight primary bars (r=hx[8], g=hx[7], b=hx[6], each replicated), 3 rainbow spectrum from hx[9:7] with 16-step up/down ramps on hx[6:3] (segments 5..7 beyond spectrum: white), 4 tri-band (vc bands: gray / primary / rainbow), 5 checkerboard white where hx[CHK_LOG2]^vc[CHK_LOG2]=1 else black, 6-7 solid black.
REQ-018 Effective mode = mode when accepted pixel has start=1, else mode_q; mode_q <= mode on every accepted start pixel, so mode never changes mid-frame.
REQ-019 Offset counter off_cnt and frame latch frame_off: on accepted start pixel frame_off <= off_cnt and, if scroll_en, off_cnt <= (off_cnt + SCROLL_STEP) wrapped modulo H_DISPLAY.
REQ-020 Effective offset = off_cnt if start=1 else frame_off; hx = hc + offset, minus H_DISPLAY when result >= H_DISPLAY; hx width = hc width + 1 before reduction.
REQ-021 scroll_en=0 freezes off_cnt (not cleared); patterns 1-5 all use hx, vc unmodified.
REQ-022 4-bit pattern values SHALL expand to CW by MSB-first bit replication (0xF -> all ones, 0x0 -> all zeros).
REQ-023 Two-stage pipeline: stage 1 registers hx, vc, start, effective mode, source r/g/b, valid; stage 2 registers generated colour into sink_frame; latency exactly 2 accepted cycles.
REQ-024 sink_frame.hc/vc/start SHALL carry the original unshifted source values.
REQ-025 stall=1 freezes both stages, mode_q, off_cnt, frame_off; no pixel dropped or duplicated; source_vld=0 bubbles propagate as sink_vld=0.
REQ-026 start on a pixel with source_vld=0 SHALL be ignored.

Reset
REQ-027 rst asserted at any time (including mid-frame or during stall) SHALL immediately clear sink_vld, stage-1 valid, sink_frame (all fields 0), off_cnt=0, frame_off=0, mode_q=RESET_MODE.
REQ-028 After rst release the first sink_vld=1 appears 2 cycles after the first accepted pixel.

Structure
REQ-029 vga_frame_t, colour widths and mode code constants (MODE_BYPASS..MODE_BLACK) SHALL live in the shared vga package/header.
REQ-030 Colour generation (hx, vc, mode -> 4-bit r/g/b) SHALL be a combinational sub-module video_pattern_gen; widening and pipeline stay in the top.

Verification
REQ-031 mode=1, scroll_en=0, pixel hc=100 vc=10 -> 2 cycles later r=g=b=replicate(4'd3).
REQ-032 mode=3, hc=136 (hx[9:7]=1, hx[6:3]=1) -> r=replicate(4'd14), g=all ones, b=0.
REQ-033 scroll_en=1, SCROLL_STEP=4, 200 frames -> off_cnt 0,4,...,636,0 (wrap at frame 160); hc=638 with offset 4 yields hx=2.
REQ-034 mode changed 0->5 mid-frame -> current frame stays bypass; next start pixel and frame show checkerboard, (hc=32,vc=0) white.
REQ-035 stall=1 for 7 cycles with 3 pixels in flight -> outputs held, all pixels emerge in order once, none lost.
REQ-036 rst pulsed mid-frame with stall=1 -> sink_vld=0 and sink_frame=0 without a clock edge; mode_q=RESET_MODE.
